fc_infer_ctrl: RTL and testbench

Sequencing controller for one fully-connected layer wrapper (`fc_layer_*`, e.g. `fc_layer_fc3`). It accepts one feature vector over a ready/valid stream and buffers all `INPUT_SIZE` elements. It then replays them back-to-back into the layer's `valid_in`/`input_data` port and waits, with a watchdog, for the layer's `valid_out`. When the result arrives it captures all `NUM_NEURONS` accumulators, runs a sequential signed argmax, and presents class index plus winning score on an output handshake. It sits between the upstream feature producer and the classifier result sink.

---
 rtl/fc_infer_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fc_infer_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_infer_ctrl.sv
// Sequencing controller for a fully-connected layer: buffer a feature vector,
// replay it as an unbroken burst into the layer, wait for the result with a
// watchdog, then pick the highest-scoring neuron by sequential signed argmax.
module fc_infer_ctrl #(
  parameter int unsigned INPUT_SIZE     = 16,
  parameter int unsigned NUM_NEURONS    = 10,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  input  logic signed [DATA_WIDTH-1:0]        s_data,
  output logic                                s_ready,
  output logic                                fc_valid_in,
  output logic signed [DATA_WIDTH-1:0]        fc_data,
  input  logic                                fc_valid_out,
  input  logic signed [ACC_WIDTH-1:0]         fc_out [NUM_NEURONS],
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic        [$clog2(NUM_NEURONS)-1:0] m_class,
  output logic signed [ACC_WIDTH-1:0]         m_score,
  output logic                                busy,
  output logic                                err
);

  localparam int unsigned IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned CLS_W = $clog2(NUM_NEURONS);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_NEURONS - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOAD, ST_ISSUE, ST_WAIT, ST_ARGMAX, ST_DONE, ST_ERROR
  } state_t;

  state_t                      r_state, w_next;
  logic signed [DATA_WIDTH-1:0] r_buf   [INPUT_SIZE];
  logic signed [ACC_WIDTH-1:0]  r_score [NUM_NEURONS];
  logic [IDX_W-1:0]            r_wr_idx, r_rd_idx, w_rd_nxt;
  logic [TO_W-1:0]             r_to_cnt;
  logic [CLS_W-1:0]            r_arg_idx, r_best_idx, w_win_idx;
  logic signed [ACC_WIDTH-1:0] r_best_score, w_win_score;
  logic                        r_s_ready, r_fc_valid_in, r_m_valid, r_busy, r_err;
  logic signed [DATA_WIDTH-1:0] r_fc_data;
  logic [CLS_W-1:0]            r_m_class;
  logic signed [ACC_WIDTH-1:0] r_m_score;
  logic                        w_accept, w_load_last, w_issue_last, w_capture, w_arg_last, w_take;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_next;
  end

  // Next-state decode and datapath strobes
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_load_last  = 1'b0;
    w_issue_last = 1'b0;
    w_capture    = 1'b0;
    w_arg_last   = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (s_valid) begin
          w_accept = 1'b1;
          if (r_wr_idx == LAST_IDX) begin
            w_load_last = 1'b1;
            w_next      = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (r_rd_idx == LAST_IDX) begin
          w_issue_last = 1'b1;
          w_next       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result on the final watchdog cycle still counts as success
        if (fc_valid_out) begin
          w_capture = 1'b1;
          w_next    = ST_ARGMAX;
        end else if (r_to_cnt == LAST_TO) begin
          w_next = ST_ERROR;
        end
      end
      ST_ARGMAX: begin
        if (r_arg_idx == LAST_CLS) begin
          w_arg_last = 1'b1;
          w_next     = ST_DONE;
        end
      end
      ST_DONE:  if (m_ready) w_next = ST_LOAD;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_LOAD;
    endcase
  end

  // Signed strict compare so ties keep the lowest index
  always_comb begin
    w_rd_nxt    = IDX_W'(r_rd_idx + 1'b1);
    w_take      = (r_state == ST_ARGMAX) && (r_score[r_arg_idx] > r_best_score);
    w_win_idx   = w_take ? r_arg_idx : r_best_idx;
    w_win_score = w_take ? r_score[r_arg_idx] : r_best_score;
  end

  // Handshake/status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready     <= 1'b1;
      r_fc_valid_in <= 1'b0;
      r_m_valid     <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_s_ready     <= (w_next == ST_LOAD);
      r_fc_valid_in <= (w_next == ST_ISSUE);
      r_m_valid     <= (w_next == ST_DONE);
      r_busy        <= (w_next != ST_LOAD) && (w_next != ST_ERROR);
      r_err         <= r_err | (w_next == ST_ERROR);
    end
  end

  // Buffer, burst replay, watchdog, capture and argmax datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(INPUT_SIZE); i++)  r_buf[i]   <= '0;
      for (int i = 0; i < int'(NUM_NEURONS); i++) r_score[i] <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_to_cnt     <= '0;
      r_arg_idx    <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_fc_data    <= '0;
      r_m_class    <= '0;
      r_m_score    <= '0;
    end else begin
      if (w_accept) begin
        r_buf[r_wr_idx] <= s_data;
        r_wr_idx        <= w_load_last ? '0 : IDX_W'(r_wr_idx + 1'b1);
      end
      // Preload the first beat so the burst starts the cycle after the last accept
      if (w_load_last) r_fc_data <= (r_wr_idx == '0) ? s_data : r_buf[0];
      if (r_state == ST_ISSUE) begin
        r_rd_idx  <= w_issue_last ? '0 : w_rd_nxt;
        r_fc_data <= w_issue_last ? '0 : r_buf[w_rd_nxt];
      end
      if (w_issue_last) r_to_cnt <= '0;
      else if (r_state == ST_WAIT && !fc_valid_out) r_to_cnt <= TO_W'(r_to_cnt + 1'b1);
      if (w_capture) begin
        for (int i = 0; i < int'(NUM_NEURONS); i++) r_score[i] <= fc_out[i];
        r_best_idx   <= '0;
        r_best_score <= fc_out[0];
        r_arg_idx    <= CLS_W'(1);
      end
      if (r_state == ST_ARGMAX) begin
        r_best_idx   <= w_win_idx;
        r_best_score <= w_win_score;
        r_arg_idx    <= w_arg_last ? '0 : CLS_W'(r_arg_idx + 1'b1);
        if (w_arg_last) begin
          r_m_class <= w_win_idx;
          r_m_score <= w_win_score;
        end
      end
    end
  end

  // Port drive
  always_comb begin
    s_ready     = r_s_ready;
    fc_valid_in = r_fc_valid_in;
    fc_data     = r_fc_data;
    m_valid     = r_m_valid;
    m_class     = r_m_class;
    m_score     = r_m_score;
    busy        = r_busy;
    err         = r_err;
  end

endmodule

// File: tb/tb_fc_infer_ctrl.sv
// Directed bench for fc_infer_ctrl with a behavioural layer stub.
module tb_fc_infer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic signed [15:0] s_data = '0;
  logic s_ready, fc_valid_in;
  logic signed [15:0] fc_data;
  logic fc_valid_out = 1'b0;
  logic signed [31:0] fc_out [10];
  logic m_valid;
  logic m_ready = 1'b0;
  logic [3:0] m_class;
  logic signed [31:0] m_score;
  logic busy, err;

  int n_checks = 0;
  int n_fail = 0;

  logic signed [15:0] vec [16];
  logic signed [15:0] beats [16];
  int sc [10];
  int nbeats, first_k, latency, err_k, bad;
  bit load_ok;

  always #5 clk = ~clk;

  fc_infer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fc_valid_in(fc_valid_in), .fc_data(fc_data),
    .fc_valid_out(fc_valid_out), .fc_out(fc_out),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_score(m_score),
    .busy(busy), .err(err)
  );

  // Stimulus helpers: start and end at a falling edge
  task automatic set_scores();
    for (int i = 0; i < 10; i++) fc_out[i] = 32'(sc[i]);
  endtask

  task automatic load_vector(input bit rand_valid, output bit ok);
    int i = 0;
    bit vld, rdy;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      vld = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = vld;
      s_data = vec[i];
      rdy = s_ready;
      @(negedge clk);
      if (vld && rdy) begin
        i++;
        if (i == 16) begin ok = 1'b1; break; end
      end
    end
    s_valid = 1'b0;
  endtask

  // Layer stub: records beats, raises fc_valid_out after L idle WAIT cycles (L<0: never)
  task automatic run_result(input int L, input int budget);
    int last_k = 0;
    nbeats = 0; first_k = -1; latency = -1; err_k = -1;
    for (int k = 1; k <= budget; k++) begin
      if (err === 1'b1 && err_k < 0) err_k = k;
      if (m_valid === 1'b1) begin latency = k; break; end
      if (fc_valid_in === 1'b1) begin
        if (nbeats < 16) beats[nbeats] = fc_data;
        if (first_k < 0) first_k = k;
        nbeats++;
        last_k = k;
      end
      fc_valid_out = (L >= 0) && (nbeats > 0) && (fc_valid_in !== 1'b1) && (k == last_k + 1 + L);
      @(negedge clk);
    end
    fc_valid_out = 1'b0;
  endtask

  function automatic int beat_errors();
    int e = 0;
    for (int i = 0; i < 16; i++) if (beats[i] !== vec[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready got=%0b exp=1", s_ready); end
    n_checks++; if (fc_valid_in !== 1'b0) begin n_fail++; $display("FAIL rst_fc_valid_in got=%0b exp=0", fc_valid_in); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%0b exp=0", m_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", err); end
    n_checks++; if (fc_data !== 16'sd0) begin n_fail++; $display("FAIL rst_fc_data got=%0d exp=0", fc_data); end
    n_checks++; if (m_class !== 4'd0) begin n_fail++; $display("FAIL rst_m_class got=%0d exp=0", m_class); end
    n_checks++; if (m_score !== 32'sd0) begin n_fail++; $display("FAIL rst_m_score got=%0d exp=0", m_score); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got s_ready=%0b busy=%0b exp 1/0", s_ready, busy); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) vec[i] = 16'(i + 1);
    sc = '{5, -3, 9, 9, 0, 0, 0, 0, 0, 0};
    set_scores();
    load_vector(1'b0, load_ok);
    n_checks++; if (load_ok !== 1'b1) begin n_fail++; $display("FAIL basic_load got=%0b exp=1", load_ok); end
    run_result(4, 200);
    n_checks++; if (first_k !== 1) begin n_fail++; $display("FAIL basic_first_beat got=%0d exp=1", first_k); end
    n_checks++; if (nbeats !== 16) begin n_fail++; $display("FAIL basic_beats got=%0d exp=16", nbeats); end
    bad = beat_errors();
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL basic_beat_order got=%0d wrong exp=0", bad); end
    n_checks++; if (latency !== 31) begin n_fail++; $display("FAIL basic_latency got=%0d exp=31", latency); end
    n_checks++; if (m_class !== 4'd2) begin n_fail++; $display("FAIL basic_class got=%0d exp=2", m_class); end
    n_checks++; if (m_score !== 32'sd9) begin n_fail++; $display("FAIL basic_score got=%0d exp=9", m_score); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_to_load got=%0b exp=1", s_ready); end
    n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after_hs got m_valid=%0b busy=%0b exp 0/0", m_valid, busy); end
  endtask

  task automatic test_negative();
    for (int i = 0; i < 16; i++) vec[i] = 16'(-(i * 7) + 3);
    sc = '{-10, -2, -7, -20, -30, -40, -15, -25, -35, -50};
    set_scores();
    load_vector(1'b0, load_ok);
    run_result(0, 200);
    n_checks++; if (latency !== 27) begin n_fail++; $display("FAIL neg_latency got=%0d exp=27", latency); end
    n_checks++; if (m_class !== 4'd1) begin n_fail++; $display("FAIL neg_class got=%0d exp=1", m_class); end
    n_checks++; if (m_score !== -32'sd2) begin n_fail++; $display("FAIL neg_score got=%0d exp=-2", m_score); end
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
  endtask

  task automatic test_random_valid();
    for (int i = 0; i < 16; i++) vec[i] = 16'($urandom);
    sc = '{0, 0, 0, 0, 8, 0, 0, 8, 0, 0};
    set_scores();
    load_vector(1'b1, load_ok);
    n_checks++; if (load_ok !== 1'b1) begin n_fail++; $display("FAIL rand_load got=%0b exp=1", load_ok); end
    run_result(4, 200);
    n_checks++; if (nbeats !== 16) begin n_fail++; $display("FAIL rand_beats got=%0d exp=16", nbeats); end
    bad = beat_errors();
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_beat_order got=%0d wrong exp=0", bad); end
    n_checks++; if (latency !== 31) begin n_fail++; $display("FAIL rand_latency got=%0d exp=31", latency); end
    n_checks++; if (m_class !== 4'd4 || m_score !== 32'sd8) begin n_fail++; $display("FAIL rand_tie got class=%0d score=%0d exp 4/8", m_class, m_score); end
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 16; i++) vec[i] = 16'(i * 3);
    sc = '{3, 7, 7, 1, 0, 0, 0, 0, 0, 0};
    set_scores();
    load_vector(1'b0, load_ok);
    run_result(1, 200);
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL hold_reach_done got=%0b exp=1", m_valid); end
    for (int i = 0; i < 10; i++) fc_out[i] = 32'sd100;
    for (int c = 0; c < 20; c++) begin
      n_checks++; if (m_valid !== 1'b1 || m_class !== 4'd1 || m_score !== 32'sd7) begin n_fail++; $display("FAIL hold_result cyc=%0d got v=%0b class=%0d score=%0d exp 1/1/7", c, m_valid, m_class, m_score); end
      n_checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_status cyc=%0d got s_ready=%0b busy=%0b exp 0/1", c, s_ready, busy); end
      fc_valid_out = c[0];
      s_valid = 1'b1;
      s_data = 16'sh7fff;
      @(negedge clk);
    end
    fc_valid_out = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    n_checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got s_ready=%0b m_valid=%0b exp 1/0", s_ready, m_valid); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) vec[i] = 16'(i);
    load_vector(1'b0, load_ok);
    run_result(-1, 120);
    n_checks++; if (err_k !== 81) begin n_fail++; $display("FAIL to_err_cycle got=%0d exp=81", err_k); end
    n_checks++; if (latency !== -1) begin n_fail++; $display("FAIL to_no_result got=%0d exp=-1", latency); end
    n_checks++; if (err !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 || fc_valid_in !== 1'b0) begin
      n_fail++; $display("FAIL to_error_state got err=%0b s_ready=%0b busy=%0b m_valid=%0b fvi=%0b exp 1/0/0/0/0", err, s_ready, busy, m_valid, fc_valid_in);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (err !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL to_reset_clear got err=%0b s_ready=%0b exp 0/1", err, s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_issue();
    for (int i = 0; i < 16; i++) vec[i] = 16'(50 + i);
    load_vector(1'b0, load_ok);
    for (int k = 1; k < 7; k++) @(negedge clk);
    n_checks++; if (fc_valid_in !== 1'b1 || fc_data !== vec[6]) begin n_fail++; $display("FAIL mid_issue_beat got fvi=%0b data=%0d exp 1/%0d", fc_valid_in, fc_data, vec[6]); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (fc_valid_in !== 1'b0 || fc_data !== 16'sd0 || s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_issue_reset got fvi=%0b data=%0d s_ready=%0b busy=%0b m_valid=%0b", fc_valid_in, fc_data, s_ready, busy, m_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) vec[i] = 16'(100 - i * 3);
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    set_scores();
    load_vector(1'b0, load_ok);
    run_result(2, 200);
    bad = beat_errors();
    n_checks++; if (nbeats !== 16 || bad !== 0) begin n_fail++; $display("FAIL after_reset_beats got n=%0d wrong=%0d exp 16/0", nbeats, bad); end
    n_checks++; if (latency !== 29) begin n_fail++; $display("FAIL after_reset_latency got=%0d exp=29", latency); end
    n_checks++; if (m_class !== 4'd9 || m_score !== 32'sd10) begin n_fail++; $display("FAIL after_reset_argmax got class=%0d score=%0d exp 9/10", m_class, m_score); end
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) fc_out[i] = '0;
    test_reset();
    test_basic();
    test_negative();
    test_random_valid();
    test_done_hold();
    test_timeout();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
